// File: rtl/tick_timer_ctrl.sv
// Countdown timer controller with an owned 1 Hz / 10 Hz clock-enable prescaler.
// Define TICK_AUTO_RELOAD_EN to reload from rl at expiry instead of entering DONE.
module tick_timer_ctrl #(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tmod,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             ce_tick,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] DIV_SLOW_M1 = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] DIV_FAST_M1 = PRE_W'(CLK_HZ / 10 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] div_m1;
    logic [CNT_W-1:0] rl;

    assign state = state_q;

    // Greater-or-equal rather than equality so a switch to the faster rate mid-period ticks at once.
    always_comb begin
        div_m1  = tmod ? DIV_FAST_M1 : DIV_SLOW_M1;
        ce_tick = (state_q == ST_RUN) && (pre >= div_m1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pre     <= '0;
            count   <= '0;
            rl      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state_q <= ST_IDLE;
                pre     <= '0;
                count   <= '0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        pre <= '0;
                        if (load) begin
                            count <= load_val;
                            rl    <= load_val;
                        end else if (!pause && start && count != '0) begin
                            state_q <= ST_RUN;
                            busy    <= 1'b1;
                        end
                    end

                    ST_RUN: begin
                        pre <= ce_tick ? '0 : pre + 1'b1;
                        if (pause) begin
                            state_q <= ST_PAUSE;
                        end
                        // Expiry is assigned last so it overrides a coincident pause.
                        if (ce_tick) begin
                            if (count == CNT_W'(1)) begin
                                done <= 1'b1;
`ifdef TICK_AUTO_RELOAD_EN
                                count <= rl;
`else
                                count   <= '0;
                                state_q <= ST_DONE;
                                busy    <= 1'b0;
                                pre     <= '0;
`endif
                            end else begin
                                count <= count - 1'b1;
                            end
                        end
                    end

                    ST_PAUSE: begin
                        if (!pause && start) begin
                            state_q <= ST_RUN;
                        end
                    end

                    ST_DONE: begin
                        pre <= '0;
                        if (load) begin
                            count   <= load_val;
                            rl      <= load_val;
                            state_q <= ST_IDLE;
                        end else if (!pause && start && rl != '0) begin
                            count   <= rl;
                            state_q <= ST_RUN;
                            busy    <= 1'b1;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Self-checking bench for tick_timer_ctrl at CLK_HZ=20: vector table plus pause, reset, restart sequences.
module tb_tick_timer_ctrl;

    localparam int CLK_HZ = 20;
    localparam int CNT_W  = 14;
`ifdef TICK_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tmod;
    logic             start;
    logic             pause;
    logic             clear;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             ce_tick;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             clear;
        logic             load;
        logic             pause;
        logic             start;
        logic             tmod;
        logic [CNT_W-1:0] load_val;
        int               ncyc;
        logic [1:0]       exp_state;
        logic [CNT_W-1:0] exp_count;
        logic             exp_busy;
        logic             exp_done;
        logic             exp_tick;
    } vec_t;

    vec_t vecs[$];

    tick_timer_ctrl #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tmod     (tmod),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .ce_tick  (ce_tick),
        .count    (count),
        .state    (state),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit c, bit l, bit p, bit s, bit t, int val, int n,
                                int st, int cnt, bit b, bit d, bit tk);
        vec_t v;
        v.clear     = c;
        v.load      = l;
        v.pause     = p;
        v.start     = s;
        v.tmod      = t;
        v.load_val  = CNT_W'(val);
        v.ncyc      = n;
        v.exp_state = 2'(st);
        v.exp_count = CNT_W'(cnt);
        v.exp_busy  = b;
        v.exp_done  = d;
        v.exp_tick  = tk;
        return v;
    endfunction

    // Outputs are sampled 1 time unit after the rising edge, inputs change there too.
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(string name, int st, int cnt, bit b, bit d, bit tk);
        checks += 5;
        if (state !== 2'(st)) begin
            errors++;
            $display("[TB] FAIL %s.state: got %0d expected %0d", name, state, st);
        end
        if (count !== CNT_W'(cnt)) begin
            errors++;
            $display("[TB] FAIL %s.count: got %0d expected %0d", name, count, cnt);
        end
        if (busy !== b) begin
            errors++;
            $display("[TB] FAIL %s.busy: got %b expected %b", name, busy, b);
        end
        if (done !== d) begin
            errors++;
            $display("[TB] FAIL %s.done: got %b expected %b", name, done, d);
        end
        if (ce_tick !== tk) begin
            errors++;
            $display("[TB] FAIL %s.ce_tick: got %b expected %b", name, ce_tick, tk);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        clear    = v.clear;
        load     = v.load;
        pause    = v.pause;
        start    = v.start;
        tmod     = v.tmod;
        load_val = v.load_val;
        step(1);
        clear = 1'b0;
        load  = 1'b0;
        pause = 1'b0;
        start = 1'b0;
        if (v.ncyc > 1) step(v.ncyc - 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        tmod     = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = '0;

        // 1 Hz: load 3, start, ticks every 20 cycles, expiry 60 cycles after RUN entry
        vecs.push_back(mk(0,1,0,0,0, 3,  1, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0, 0,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 19, 1, 3, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,  1, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 39, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,0, 0,  1, AUTO ? 1 : 3, AUTO ? 3 : 0, AUTO, 1, 0));
        vecs.push_back(mk(0,0,0,0,0, 0,  1, AUTO ? 1 : 3, AUTO ? 3 : 0, AUTO, 0, 0));
        vecs.push_back(mk(1,0,0,0,0, 0,  1, 0, 0, 0, 0, 0));
        // 10 Hz: load 5, tick every 2 cycles, expiry 10 cycles after RUN entry
        vecs.push_back(mk(0,1,0,0,1, 5,  1, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, 0,  1, 1, 5, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,1, 0,  1, 1, 5, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,1, 0,  1, 1, 4, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,1, 0,  7, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,1, 0,  1, AUTO ? 1 : 3, AUTO ? 5 : 0, AUTO, 1, 0));
        vecs.push_back(mk(1,0,0,0,0, 0,  1, 0, 0, 0, 0, 0));
        // zero load cannot start
        vecs.push_back(mk(0,1,0,0,0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0, 0,  1, 0, 0, 0, 0, 0));
        // load ignored in RUN, clear beats load
        vecs.push_back(mk(0,1,0,0,0, 3,  1, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0, 0,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 7,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1,1,0,0,0, 9,  1, 0, 0, 0, 0, 0));

        #3;
        checkOutput("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        checkOutput("post_reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_count,
                        vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_tick);
        end

        // pause at pre=4 holds count and prescaler; next tick 15 cycles after resume
        applyStimulus(mk(0,1,0,0,0, 4, 1, 0, 4, 0, 0, 0));
        applyStimulus(mk(0,0,0,1,0, 0, 1, 1, 4, 1, 0, 0));
        step(23);
        applyStimulus(mk(0,0,1,0,0, 0, 1, 2, 3, 1, 0, 0));
        checkOutput("pause_enter", 2, 3, 1, 0, 0);
        step(100);
        checkOutput("pause_hold", 2, 3, 1, 0, 0);
        applyStimulus(mk(0,0,0,1,0, 0, 1, 1, 3, 1, 0, 0));
        checkOutput("resume", 1, 3, 1, 0, 0);
        step(14);
        checkOutput("resume_pre_tick", 1, 3, 1, 0, 0);
        step(1);
        checkOutput("resume_tick", 1, 3, 1, 0, 1);
        step(1);
        checkOutput("resume_dec", 1, 2, 1, 0, 0);
        applyStimulus(mk(1,0,0,0,0, 0, 1, 0, 0, 0, 0, 0));

        // asynchronous reset in the middle of a run
        applyStimulus(mk(0,1,0,0,0, 5, 1, 0, 5, 0, 0, 0));
        applyStimulus(mk(0,0,0,1,0, 0, 5, 1, 5, 1, 0, 0));
        checkOutput("pre_async_reset", 1, 5, 1, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1);
        checkOutput("async_release", 0, 0, 0, 0, 0);

`ifdef TICK_AUTO_RELOAD_EN
        // count cycles 2,1,2,1 with done every 40 cycles and no DONE state
        applyStimulus(mk(0,1,0,0,0, 2, 1, 0, 2, 0, 0, 0));
        applyStimulus(mk(0,0,0,1,0, 0, 1, 1, 2, 1, 0, 0));
        step(20);
        checkOutput("auto_first_dec", 1, 1, 1, 0, 0);
        step(20);
        checkOutput("auto_reload1", 1, 2, 1, 1, 0);
        step(1);
        checkOutput("auto_done_drop", 1, 2, 1, 0, 0);
        step(19);
        checkOutput("auto_second_dec", 1, 1, 1, 0, 0);
        step(20);
        checkOutput("auto_reload2", 1, 2, 1, 1, 0);
`else
        // restart from DONE reuses the reload value
        applyStimulus(mk(0,1,0,0,0, 2, 1, 0, 2, 0, 0, 0));
        applyStimulus(mk(0,0,0,1,0, 0, 1, 1, 2, 1, 0, 0));
        step(40);
        checkOutput("restart_done", 3, 0, 0, 1, 0);
        step(3);
        checkOutput("restart_idle_done", 3, 0, 0, 0, 0);
        applyStimulus(mk(0,0,0,1,0, 0, 1, 1, 2, 1, 0, 0));
        checkOutput("restart_run", 1, 2, 1, 0, 0);
        step(19);
        checkOutput("restart_tick", 1, 2, 1, 0, 1);
        step(1);
        checkOutput("restart_dec", 1, 1, 1, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_timer_ctrl.md
# tick_timer_ctrl

Countdown timer controller that owns and sequences a 1 Hz / 10 Hz clock-enable prescaler. It starts, pauses, resumes, reloads and clears a tick-driven down-counter. It emits the gated tick enable, the remaining count and an expiry pulse. It sits between the front-panel control logic (buttons, mode switch) and the display/alarm blocks that consume the count and done event.

## Interface
- CLK_HZ, 50000000, system clock frequency; must be a multiple of 10 and ≥ 20.
- CNT_W, 14, width of the countdown value.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tmod  input  1  tick rate select: 1 = 10 Hz (divide CLK_HZ/10), 0 = 1 Hz (divide CLK_HZ).
- start  input  1  start, resume or restart request; level-sampled each cycle.
- pause  input  1  pause request.
- clear  input  1  abort to IDLE and zero the count.
- load  input  1  load load_val; honoured only in IDLE or DONE.
- load_val  input  CNT_W  value for load.
- ce_tick  output  1  one-cycle prescaler tick, only while in RUN.
- count  output  CNT_W  remaining ticks.
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle registered pulse on expiry.

## Operation
- Prescaler counter pre is $clog2(CLK_HZ) bits wide. Divisor DIV = tmod ? CLK_HZ/10 : CLK_HZ.
- In RUN, pre increments every cycle. When pre ≥ DIV-1, pre wraps to 0 and ce_tick fires that cycle.
- The ≥ compare covers a tmod switch mid-period: the tick fires on the next cycle.
- pre holds in PAUSE. pre is forced to 0 in IDLE and DONE.
- reload register rl is set to load_val on every honoured load. clear does not modify rl.
- Input priority within one cycle: clear > load > pause > start.
- IDLE:
  - load: count ← load_val, rl ← load_val.
  - start with count≠0: go to RUN.
  - start with count=0: ignored.
- RUN:
  - On ce_tick, count decrements by 1.
  - If count=1 at the tick: count ← 0, state ← DONE, done pulses next cycle.
  - pause: go to PAUSE. If a tick coincides with pause, the decrement still applies.
  - load is ignored.
- PAUSE:
  - start: back to RUN; pre resumes from its held value.
  - load is ignored.
- DONE:
  - load: count ← load_val, rl ← load_val, state ← IDLE.
  - start with rl≠0: count ← rl, pre ← 0, go to RUN.
- Any state, clear: count ← 0, pre ← 0, go to IDLE, done ← 0.
- The count never wraps below 0. RUN implies count≠0 and rl≠0.

## Timing
- All outputs are registered except ce_tick, which decodes from pre and state in the same cycle.
- Reset values: state=IDLE, count=0, rl=0, pre=0, ce_tick=0, busy=0, done=0.
- From start sampled in IDLE, state=RUN one cycle later. The first ce_tick comes DIV cycles after entering RUN.
- count updates on the clock edge following the ce_tick cycle.
- done is high for exactly one cycle, coincident with the first cycle of state=DONE.
- rst_n asserted mid-run forces reset values immediately, without waiting for a clock edge. Deassertion is taken at the next clk edge.

## Configuration
- TICK_AUTO_RELOAD_EN defined:
  - At expiry in RUN, count ← rl instead of 0 and the state stays RUN.
  - pre wraps normally and the tick cadence is unbroken.
  - done still pulses for one cycle. DONE is never entered from RUN.
- Undefined: expiry behaviour is as described under Operation.

## Test plan
- CLK_HZ=20, tmod=0, load 3, start → ce_tick every 20 cycles; count 3→2→1→0; done pulses once, 60 cycles after RUN entry; state=DONE.
- CLK_HZ=20, tmod=1, load 5, start → tick every 2 cycles; expiry 10 cycles after RUN entry.
- Load 4, start, pause at cycle 25 (pre=4), hold 100 cycles, start → count stays 3 during PAUSE; next tick 15 cycles after resume.
- Load 0, start → state stays IDLE. Then clear and load asserted together in RUN → IDLE, count=0.
- rst_n low mid-RUN → state=IDLE, count=0, busy=0 asynchronously. Also, start in DONE after load 2 → restarts with count=2.
- With TICK_AUTO_RELOAD_EN, load 2, start → count 2,1,2,1…; done pulses every 40 cycles; state stays RUN.
